// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// window timed from clkin. With the default 1 s gate the result reads in Hz.
module freq_meter #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned GATE_MS     = 1000,
    parameter int unsigned COUNT_WIDTH = 27
) (
    input  logic                   clkin,
    input  logic                   rst_n,
    input  logic                   sig_in,
    input  logic                   start,
    input  logic                   continuous,
    output logic [COUNT_WIDTH-1:0] freq_out,
    output logic                   freq_valid,
    output logic                   busy,
    output logic                   overflow
);

    localparam int unsigned GATE_CYCLES = CLK_FREQ / 1000 * GATE_MS;
    localparam int unsigned GATE_W      = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("freq_meter: GATE_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   s1;
    logic                   s2;
    logic                   s3;
    logic                   edge_pulse;
    logic [GATE_W-1:0]      gate_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt_next;
    logic                   ovf;
    logic                   ovf_next;
    logic                   gate_done;

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 & ~s3;
    assign gate_done  = (state == GATE) && (gate_cnt == GATE_LAST);

    // State register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: requests are only honoured from IDLE, never queued.
    // NOTE: next_state is given a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start || continuous) next_state = GATE;
            GATE:    if (gate_cnt == GATE_LAST) next_state = LATCH;
            LATCH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy       = (state == GATE) || (state == LATCH);
        freq_valid = (state == LATCH);
    end

    // Saturating edge count for this cycle; ovf marks a lost edge.
    always_comb begin
        edge_cnt_next = edge_cnt;
        ovf_next      = ovf;
        if (edge_pulse) begin
            if (&edge_cnt) begin
                ovf_next = 1'b1;
            end else begin
                edge_cnt_next = edge_cnt + 1'b1;
            end
        end
    end

    // Gate and edge counters run only in GATE and are cleared otherwise, so
    // each gate starts from zero and edges outside GATE are never counted.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_cnt_next;
            ovf      <= ovf_next;
        end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end
    end

    // Result register loads with the final count (including an edge in the
    // last gate cycle) so it is already valid during the LATCH cycle.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            freq_out <= '0;
            overflow <= 1'b0;
        end else if (gate_done) begin
            freq_out <= edge_cnt_next;
            overflow <= ovf_next;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two freq_meter instances (wide and 3-bit counter) share one
// stimulus; a window-based behavioural model predicts every output each cycle.
module tb_freq_meter;

    localparam int G  = 100;
    localparam int WW = 16;
    localparam int WN = 3;

    logic          clkin      = 1'b0;
    logic          rst_n      = 1'b0;
    logic          sig_in     = 1'b0;
    logic          start      = 1'b0;
    logic          continuous = 1'b0;

    logic [WW-1:0] freq_w;
    logic          valid_w, busy_w, ovf_w;
    logic [WN-1:0] freq_n;
    logic          valid_n, busy_n, ovf_n;

    freq_meter #(.CLK_FREQ(1000), .GATE_MS(100), .COUNT_WIDTH(WW)) dut_w (
        .clkin(clkin), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .freq_out(freq_w), .freq_valid(valid_w),
        .busy(busy_w), .overflow(ovf_w)
    );

    freq_meter #(.CLK_FREQ(1000), .GATE_MS(100), .COUNT_WIDTH(WN)) dut_n (
        .clkin(clkin), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .freq_out(freq_n), .freq_valid(valid_n),
        .busy(busy_n), .overflow(ovf_n)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Signal generator: 0 = manual level, 1 = fixed period, 2 = random phases.
    int   gen_mode   = 0;
    int   gen_period = 10;
    logic gen_level  = 1'b0;
    int   gen_cnt    = 0;
    int   gen_left   = 3;

    always @(negedge clkin) begin
        case (gen_mode)
            1: sig_in = ((gen_cnt % gen_period) < (gen_period / 2));
            2: begin
                if (gen_left > 1) gen_left--;
                else begin
                    sig_in   = ~sig_in;
                    gen_left = $urandom_range(2, 7);
                end
            end
            default: sig_in = gen_level;
        endcase
        gen_cnt++;
    end

    // Model: a gate is a window of G cycles starting the cycle after a request
    // seen in idle, followed by one latch cycle. Edges are rising transitions
    // of the sampled input, seen two cycles after the sampling clock.
    int m_cyc, m_gate_start, m_phase, m_cnt, m_result, m_off;
    bit m_edge;
    bit m_samp[$];

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            m_samp.delete();
            repeat (3) m_samp.push_back(1'b0);
            m_cyc = 0; m_gate_start = -1; m_phase = 0;
            m_cnt = 0; m_result = 0; m_edge = 1'b0;
        end else begin
            if (m_phase == 1 && m_edge) m_cnt++;
            m_cyc++;
            if (m_phase == 0 && (start || continuous)) begin
                m_gate_start = m_cyc;
                m_cnt = 0;
            end
            if (m_gate_start < 0) m_phase = 0;
            else begin
                m_off = m_cyc - m_gate_start;
                if (m_off < G) m_phase = 1;
                else if (m_off == G) begin
                    m_phase  = 2;
                    m_result = m_cnt;
                end else begin
                    m_phase = 0;
                    m_gate_start = -1;
                end
            end
            m_samp.push_back(sig_in);
            void'(m_samp.pop_front());
            m_edge = m_samp[1] && !m_samp[0];
        end
    end

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    int valid_total = 0;
    always @(negedge clkin) begin
        if (rst_n) begin
            check("freq_w",  freq_w,  sat(m_result, WW));
            check("ovf_w",   ovf_w,   m_result > (1 << WW) - 1);
            check("valid_w", valid_w, m_phase == 2);
            check("busy_w",  busy_w,  m_phase != 0);
            check("freq_n",  freq_n,  sat(m_result, WN));
            check("ovf_n",   ovf_n,   m_result > (1 << WN) - 1);
            check("valid_n", valid_n, m_phase == 2);
            check("busy_n",  busy_n,  m_phase != 0);
            if (valid_w) valid_total++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    // Pulse start and wait for the result; returns latency and busy cycles.
    task automatic measure(output int lat, output int bc);
        start = 1'b1;
        lat = 0;
        bc = 0;
        do begin
            tick(1);
            start = 1'b0;
            lat++;
            if (busy_w) bc++;
        end while (!valid_w && lat < 400);
        check("measure_valid_seen", valid_w, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!valid_w && n < 400);
        check("wait_valid_seen", valid_w, 1);
    endtask

    initial begin
        int lat, bc, n, v0, cnt;

        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("rst_freq",  freq_w,  0);
        check("rst_valid", valid_w, 0);
        check("rst_busy",  busy_w,  0);
        check("rst_ovf",   ovf_w,   0);

        // Single measurement, period 10 started 5 cycles ahead.
        gen_mode = 1; gen_period = 10;
        tick(5);
        measure(lat, bc);
        check("t1_latency", lat, 101);
        check("t1_busy_cycles", bc, 101);
        check("t1_freq", freq_w, 10);
        check("t1_ovf", ovf_w, 0);
        check("t1_freq_sat", freq_n, 7);
        check("t1_ovf_sat", ovf_n, 1);
        tick(1);
        check("t1_idle", busy_w, 0);

        // Continuous mode.
        continuous = 1'b1;
        wait_valid(n);
        wait_valid(n);
        check("t2_period", n, 102);
        check("t2_freq_range", (freq_w == 9 || freq_w == 10), 1);
        wait_valid(n);
        check("t2_period2", n, 102);
        tick(50);
        continuous = 1'b0;
        wait_valid(n);
        check("t2_completes", n, 52);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (busy_w) cnt++;
        end
        check("t2_stays_idle", cnt, 0);

        // Saturation, then a 0 Hz gate.
        gen_period = 4;
        tick(3);
        measure(lat, bc);
        check("t3_freq_sat", freq_n, 7);
        check("t3_ovf_sat", ovf_n, 1);
        check("t3_freq_wide", freq_w, 25);
        gen_mode = 0; gen_level = 1'b0;
        tick(5);
        measure(lat, bc);
        check("t3_zero_freq", freq_n, 0);
        check("t3_zero_ovf", ovf_n, 0);
        check("t3_zero_wide", freq_w, 0);
        tick(3);

        // Edge pulse in the last gate cycle is counted.
        start = 1'b1; tick(1); start = 1'b0;
        tick(97);
        gen_level = 1'b1;
        wait_valid(n);
        check("t4_last_latency", n, 3);
        check("t4_last_counted", freq_w, 1);
        gen_level = 1'b0;
        tick(6);

        // Edge pulse in the LATCH cycle is counted in neither gate.
        continuous = 1'b1; tick(1);
        tick(98);
        gen_level = 1'b1;
        wait_valid(n);
        check("t4_latch_latency", n, 2);
        check("t4_latch_not_this", freq_w, 0);
        wait_valid(n);
        continuous = 1'b0;
        check("t4_latch_not_next", freq_w, 0);
        gen_level = 1'b0;
        tick(6);

        // Reset mid-gate.
        gen_mode = 1; gen_period = 10;
        measure(lat, bc);
        check("t5_pre_freq", freq_w, 10);
        start = 1'b1; tick(1); start = 1'b0;
        tick(50);
        rst_n = 1'b0;
        #1;
        check("t5_rst_freq", freq_w, 0);
        check("t5_rst_busy", busy_w, 0);
        check("t5_rst_valid", valid_w, 0);
        check("t5_rst_ovf_sat", ovf_n, 0);
        check("t5_rst_freq_sat", freq_n, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (valid_w || busy_w) cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (valid_w || busy_w) cnt++;
        end
        check("t5_quiet_after_rst", cnt, 0);
        measure(lat, bc);
        check("t5_new_latency", lat, 101);
        check("t5_new_freq", freq_w, 10);

        // Start ignored while busy.
        tick(2);
        v0 = valid_total;
        start = 1'b1; tick(1); tick(1); start = 1'b0;
        tick(49);
        start = 1'b1; tick(1); start = 1'b0;
        tick(49);
        start = 1'b1; tick(1); start = 1'b0;
        tick(150);
        check("t6_one_valid", valid_total - v0, 1);
        check("t6_freq", freq_w, 10);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: begin start = 1'b1; tick(1); start = 1'b0; end
                1: continuous = ~continuous;
                2: begin gen_mode = 1; gen_period = $urandom_range(4, 24); end
                default: gen_mode = 2;
            endcase
            tick($urandom_range(20, 260));
        end
        continuous = 1'b0;
        tick(250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
